shader_cluster_fabric: RTL

Parametrised job-dispatch and L2-arbitration fabric for an array of NUM_CLUSTERS shader core clusters in the GPU subsystem. It buffers incoming jobs in a FIFO and dispatches them round-robin to idle clusters. It tracks outstanding work per cluster and arbitrates all cluster L2 requests onto a single L2 port, returning read data to the requester. Unlike the fixed two-cluster generation, every cluster gets real L2 access and jobs queue instead of stalling.

---
 rtl/shader_cluster_fabric.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/shader_cluster_fabric.sv
// shader_cluster_fabric
// Buffers incoming job descriptors in a FIFO and hands them round-robin to
// idle shader clusters. It also funnels every cluster's L2 request through a
// round-robin arbiter onto one L2 port and routes read data back to the owner.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   enable_i                     gates new dispatches and new L2 latches
//   job_addr_i/valid_i/ready_o   job input (valid/ready)
//   cl_job_addr_o/valid_o        per-cluster registered dispatch pulse + address slice
//   cl_job_ready_i/done_i        per-cluster idle flag and completion pulse
//   cl_l2_req_i/we_i/addr_i/wdata_i  per-cluster L2 request, held until gnt
//   cl_l2_gnt_o/rvalid_o         one-hot grant / read-return pulses
//   cl_l2_rdata_o                shared registered read data
//   l2_req_o/we_o/addr_o/wdata_o, l2_ready_i, l2_rvalid_i, l2_rdata_i  L2 port
//   busy_o, job_done_o, jobs_done_o, busy_cycles_o, err_o  status / perf
//
// L2 FSM
//   state      | meaning
//   L2_IDLE    | no transaction; may latch a new request
//   L2_REQ     | driving l2_req_o with the latched request
//   L2_WAIT_RD | read accepted, waiting for l2_rvalid_i
module shader_cluster_fabric #(
    parameter int NUM_CLUSTERS   = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 256,
    parameter int JOB_FIFO_DEPTH = 8,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               enable_i,
    input  logic [ADDR_WIDTH-1:0]              job_addr_i,
    input  logic                               job_valid_i,
    output logic                               job_ready_o,
    output logic [NUM_CLUSTERS*ADDR_WIDTH-1:0] cl_job_addr_o,
    output logic [NUM_CLUSTERS-1:0]            cl_job_valid_o,
    input  logic [NUM_CLUSTERS-1:0]            cl_job_ready_i,
    input  logic [NUM_CLUSTERS-1:0]            cl_job_done_i,
    input  logic [NUM_CLUSTERS-1:0]            cl_l2_req_i,
    input  logic [NUM_CLUSTERS-1:0]            cl_l2_we_i,
    input  logic [NUM_CLUSTERS*ADDR_WIDTH-1:0] cl_l2_addr_i,
    input  logic [NUM_CLUSTERS*DATA_WIDTH-1:0] cl_l2_wdata_i,
    output logic [NUM_CLUSTERS-1:0]            cl_l2_gnt_o,
    output logic [NUM_CLUSTERS-1:0]            cl_l2_rvalid_o,
    output logic [DATA_WIDTH-1:0]              cl_l2_rdata_o,
    output logic                               l2_req_o,
    output logic                               l2_we_o,
    output logic [ADDR_WIDTH-1:0]              l2_addr_o,
    output logic [DATA_WIDTH-1:0]              l2_wdata_o,
    input  logic                               l2_ready_i,
    input  logic                               l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              l2_rdata_i,
    output logic                               busy_o,
    output logic                               job_done_o,
    output logic [CNT_WIDTH-1:0]               jobs_done_o,
    output logic [CNT_WIDTH-1:0]               busy_cycles_o,
    output logic                               err_o
);

    localparam int PW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int FW = $clog2(JOB_FIFO_DEPTH);

    typedef enum logic [1:0] {L2_IDLE, L2_REQ, L2_WAIT_RD} l2_state_t;

    // Job FIFO
    logic [ADDR_WIDTH-1:0] fifo_mem [JOB_FIFO_DEPTH];
    logic [FW-1:0]         wr_ptr, rd_ptr;
    logic [FW:0]           fifo_cnt;
    logic                  fifo_empty, fifo_full, push, pop;

    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == (FW+1)'(JOB_FIFO_DEPTH));
    assign job_ready_o = !fifo_full && !rst_i;
    assign push        = job_valid_i && job_ready_o;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= job_addr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Dispatch: round-robin over eligible clusters starting at dsp_ptr
    logic [NUM_CLUSTERS-1:0] outstanding, eligible, dsp_onehot;
    logic [PW-1:0]           dsp_ptr, dsp_idx;
    logic                    dsp_hit;
    int                      dsp_scan;

    assign eligible = cl_job_ready_i & ~outstanding;

    always_comb begin
        dsp_hit  = 1'b0;
        dsp_idx  = '0;
        dsp_scan = 0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            dsp_scan = int'(dsp_ptr) + k;
            if (dsp_scan >= NUM_CLUSTERS) dsp_scan = dsp_scan - NUM_CLUSTERS;
            if (!dsp_hit && eligible[dsp_scan]) begin
                dsp_hit = 1'b1;
                dsp_idx = PW'(dsp_scan);
            end
        end
    end

    assign pop        = enable_i && !fifo_empty && dsp_hit;
    assign dsp_onehot = pop ? (NUM_CLUSTERS'(1) << dsp_idx) : '0;

    // Completion accounting
    logic [NUM_CLUSTERS-1:0] done_ok, done_bad;
    logic [CNT_WIDTH-1:0]    done_cnt;
    l2_state_t               l2_state, l2_state_n;

    assign done_ok  = cl_job_done_i & outstanding;
    assign done_bad = cl_job_done_i & ~outstanding;
    assign busy_o   = !fifo_empty || (|outstanding) || (l2_state != L2_IDLE);

    always_comb begin
        done_cnt = '0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            if (done_ok[k]) done_cnt = done_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding    <= '0;
            dsp_ptr        <= '0;
            cl_job_valid_o <= '0;
            cl_job_addr_o  <= '0;
            job_done_o     <= 1'b0;
            jobs_done_o    <= '0;
            busy_cycles_o  <= '0;
            err_o          <= 1'b0;
        end else begin
            cl_job_valid_o <= '0;
            outstanding    <= (outstanding & ~done_ok) | dsp_onehot;
            if (pop) begin
                cl_job_valid_o[dsp_idx] <= 1'b1;
                cl_job_addr_o[dsp_idx*ADDR_WIDTH +: ADDR_WIDTH] <= fifo_mem[rd_ptr];
                dsp_ptr <= (dsp_idx == PW'(NUM_CLUSTERS-1)) ? '0 : dsp_idx + 1'b1;
            end
            job_done_o  <= |done_ok;
            jobs_done_o <= jobs_done_o + done_cnt;
            if (|done_bad) err_o <= 1'b1;
            if (enable_i && busy_o && !(&busy_cycles_o)) busy_cycles_o <= busy_cycles_o + 1'b1;
        end
    end

    // L2 arbitration. A cluster whose grant is visible this cycle is still
    // holding its request, so it is masked to avoid latching it twice.
    logic [NUM_CLUSTERS-1:0] l2_cand;
    logic [PW-1:0]           l2_ptr, l2_idx, l2_owner, l2_owner_next;
    logic                    l2_hit, l2_latch, lat_we;
    int                      l2_scan;

    assign l2_cand = cl_l2_req_i & ~cl_l2_gnt_o;

    always_comb begin
        l2_hit  = 1'b0;
        l2_idx  = '0;
        l2_scan = 0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            l2_scan = int'(l2_ptr) + k;
            if (l2_scan >= NUM_CLUSTERS) l2_scan = l2_scan - NUM_CLUSTERS;
            if (!l2_hit && l2_cand[l2_scan]) begin
                l2_hit = 1'b1;
                l2_idx = PW'(l2_scan);
            end
        end
    end

    assign l2_owner_next = (l2_owner == PW'(NUM_CLUSTERS-1)) ? '0 : l2_owner + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) l2_state <= L2_IDLE;
        else       l2_state <= l2_state_n;
    end

    always_comb begin
        l2_state_n = l2_state;
        l2_latch   = 1'b0;
        case (l2_state)
            L2_IDLE: begin
                if (enable_i && l2_hit) begin
                    l2_latch   = 1'b1;
                    l2_state_n = L2_REQ;
                end
            end
            L2_REQ: begin
                if (l2_ready_i) l2_state_n = lat_we ? L2_IDLE : L2_WAIT_RD;
            end
            L2_WAIT_RD: begin
                if (l2_rvalid_i) l2_state_n = L2_IDLE;
            end
            default: l2_state_n = L2_IDLE;
        endcase
    end

    assign l2_req_o = (l2_state == L2_REQ);
    assign l2_we_o  = (l2_state == L2_REQ) && lat_we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l2_ptr         <= '0;
            l2_owner       <= '0;
            lat_we         <= 1'b0;
            l2_addr_o      <= '0;
            l2_wdata_o     <= '0;
            cl_l2_gnt_o    <= '0;
            cl_l2_rvalid_o <= '0;
            cl_l2_rdata_o  <= '0;
        end else begin
            cl_l2_gnt_o    <= '0;
            cl_l2_rvalid_o <= '0;
            if (l2_latch) begin
                l2_owner   <= l2_idx;
                lat_we     <= cl_l2_we_i[l2_idx];
                l2_addr_o  <= cl_l2_addr_i[l2_idx*ADDR_WIDTH +: ADDR_WIDTH];
                l2_wdata_o <= cl_l2_wdata_i[l2_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (l2_state == L2_REQ && l2_ready_i) begin
                cl_l2_gnt_o[l2_owner] <= 1'b1;
                if (lat_we) l2_ptr <= l2_owner_next;
            end
            if (l2_state == L2_WAIT_RD && l2_rvalid_i) begin
                cl_l2_rvalid_o[l2_owner] <= 1'b1;
                cl_l2_rdata_o            <= l2_rdata_i;
                l2_ptr                   <= l2_owner_next;
            end
        end
    end

endmodule
